// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: pad sync, optional debounce, level/edge detect,
// sticky pending vector and a registered prioritised interrupt request.
module gpio_irq_ctrl #(
  parameter int N_CH        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 4,
  parameter int ID_W        = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] gpio_i,
  input  logic [N_CH-1:0] int_en_i,
  input  logic [N_CH-1:0] int_mode_i,
  input  logic [N_CH-1:0] int_pol_i,
  input  logic [N_CH-1:0] int_both_i,
  input  logic [N_CH-1:0] db_en_i,
  input  logic [15:0]     db_div_i,
  input  logic [N_CH-1:0] set_i,
  input  logic [N_CH-1:0] clr_i,
  output logic [N_CH-1:0] status_o,
  output logic            irq_o,
  output logic [ID_W-1:0] irq_id_o,
  output logic            irq_valid_o
);

  localparam int CW   = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam int WARM = SYNC_STAGES + 2;
  localparam int WW   = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
  logic [N_CH-1:0][CW-1:0]          r_cnt;
  logic [N_CH-1:0]                  r_filt;
  logic [N_CH-1:0]                  r_prev;
  logic [N_CH-1:0]                  r_status;
  logic [15:0]                      r_pre;
  logic [WW-1:0]                    r_warm;
  logic                             r_irq;
  logic [ID_W-1:0]                  r_id;

  logic [N_CH-1:0] w_sync;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_edge;
  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_status_nxt;
  logic [N_CH-1:0] w_pend;
  logic [ID_W-1:0] w_id;
  logic            w_tick;
  logic            w_warm;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_pre >= db_div_i);
  assign w_warm = (r_warm == WW'(WARM));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_pre  <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
      r_pre  <= w_tick ? 16'd0 : r_pre + 16'd1;
      if (!w_warm)
        r_warm <= r_warm + WW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!db_en_i[i]) begin
          r_filt[i] <= w_sync[i];
          r_cnt[i]  <= '0;
        end else if (w_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == CW'(DB_CNT - 1)) begin
            r_filt[i] <= w_sync[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign w_rise = r_filt & ~r_prev;
  assign w_fall = ~r_filt & r_prev;

  // Edges stay masked until prev has caught up with the first synced value.
  assign w_edge = int_mode_i & int_en_i & {N_CH{w_warm}}
                & ((int_both_i & (w_rise | w_fall))
                 | (~int_both_i & int_pol_i & w_rise)
                 | (~int_both_i & ~int_pol_i & w_fall));

  assign w_level = ~int_mode_i & int_en_i & ~(r_filt ^ int_pol_i);

  // A held level yields to a clear for one cycle and re-asserts after it;
  // edges and software sets always beat a clear.
  assign w_status_nxt = ((r_status | w_level) & ~clr_i) | w_edge | set_i;

  assign w_pend = r_status & int_en_i;

  always_comb begin
    w_id = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (w_pend[i])
        w_id = ID_W'(i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
      r_id     <= '0;
    end else begin
      r_prev   <= r_filt;
      r_status <= w_status_nxt;
      r_irq    <= |w_pend;
      r_id     <= w_id;
    end
  end

  assign status_o    = r_status;
  assign irq_o       = r_irq;
  assign irq_id_o    = r_id;
  assign irq_valid_o = r_irq;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: latency, level/edge, priority,
// debounce and reset behaviour with hand-computed expectations.
module tb_gpio_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] gpio_i;
  logic [31:0] int_en_i;
  logic [31:0] int_mode_i;
  logic [31:0] int_pol_i;
  logic [31:0] int_both_i;
  logic [31:0] db_en_i;
  logic [15:0] db_div_i;
  logic [31:0] set_i;
  logic [31:0] clr_i;
  logic [31:0] status_o;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_valid_o;

  int checks = 0;
  int errors = 0;
  int lat;
  logic seen;

  gpio_irq_ctrl #(
    .N_CH(32), .SYNC_STAGES(2), .DB_CNT(4), .ID_W(5)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .gpio_i(gpio_i),
    .int_en_i(int_en_i), .int_mode_i(int_mode_i),
    .int_pol_i(int_pol_i), .int_both_i(int_both_i),
    .db_en_i(db_en_i), .db_div_i(db_div_i),
    .set_i(set_i), .clr_i(clr_i), .status_o(status_o),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_valid_o(irq_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    gpio_i = '1;
    int_en_i = '1;
    int_mode_i = '1;
    int_pol_i = '1;
    int_both_i = '1;
    db_en_i = '0;
    db_div_i = 16'd0;
    set_i = '0;
    clr_i = '0;
    tick(4);
    check("rst_status", status_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_id", irq_id_o, 0);
    check("rst_valid", irq_valid_o, 0);

    rst_i = 1'b0;
    tick(20);
    check("warm_status", status_o, 0);
    check("warm_irq", irq_o, 0);
    int_en_i = '0;
    gpio_i = '0;
    tick(6);
    check("quiet_status", status_o, 0);

    int_both_i = '0;
    int_en_i = 32'h8;
    gpio_i[3] = 1'b1;
    tick(3);
    check("rise_early", status_o, 0);
    tick(1);
    check("rise_status", status_o, 32'h8);
    check("rise_irq_early", irq_o, 0);
    tick(1);
    check("rise_irq", irq_o, 1);
    check("rise_id", irq_id_o, 3);
    check("rise_valid", irq_valid_o, 1);
    clr_i = 32'h8;
    tick(1);
    clr_i = '0;
    check("clr_status", status_o, 0);
    check("clr_irq_lag", irq_o, 1);
    tick(1);
    check("clr_irq", irq_o, 0);
    int_en_i = '0;
    gpio_i[3] = 1'b0;
    tick(5);
    check("fall_ignored", status_o, 0);

    int_mode_i[0] = 1'b0;
    int_pol_i[0] = 1'b0;
    int_en_i = 32'h1;
    tick(2);
    check("lvl_set", status_o, 32'h1);
    clr_i = 32'h1;
    tick(1);
    clr_i = '0;
    check("lvl_clr", status_o, 0);
    tick(1);
    check("lvl_reassert", status_o, 32'h1);
    int_en_i = '0;
    int_mode_i[0] = 1'b1;
    int_pol_i[0] = 1'b1;
    clr_i = 32'h1;
    tick(1);
    clr_i = '0;
    tick(2);
    check("lvl_off", status_o, 0);
    check("lvl_off_irq", irq_o, 0);

    int_en_i = 32'h84;
    set_i = 32'h84;
    tick(1);
    set_i = '0;
    check("prio_status", status_o, 32'h84);
    tick(1);
    check("prio_irq", irq_o, 1);
    check("prio_id2", irq_id_o, 2);
    int_en_i = 32'h80;
    tick(1);
    check("prio_id7", irq_id_o, 7);
    check("prio_masked", status_o, 32'h84);
    clr_i = 32'h84;
    tick(1);
    clr_i = '0;
    check("prio_clr", status_o, 0);
    tick(1);
    check("prio_irq_off", irq_o, 0);
    check("prio_id_off", irq_id_o, 0);
    check("prio_valid_off", irq_valid_o, 0);

    set_i = 32'h200;
    clr_i = 32'h200;
    tick(1);
    set_i = '0;
    clr_i = '0;
    check("set_vs_clr", status_o, 32'h200);
    clr_i = 32'h200;
    tick(1);
    clr_i = '0;
    check("clr9", status_o, 0);
    int_en_i = 32'h2;
    gpio_i[1] = 1'b1;
    tick(3);
    clr_i = 32'h2;
    tick(1);
    clr_i = '0;
    check("rise_vs_clr", status_o, 32'h2);
    int_en_i = '0;
    gpio_i[1] = 1'b0;
    clr_i = '1;
    tick(1);
    clr_i = '0;
    tick(4);
    check("clean", status_o, 0);

    int_en_i = 32'h20;
    int_both_i[5] = 1'b1;
    db_en_i = 32'h20;
    db_div_i = 16'd9;
    tick(3);
    seen = 1'b0;
    gpio_i[5] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (status_o[5]) seen = 1'b1;
    end
    gpio_i[5] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (status_o[5]) seen = 1'b1;
    end
    check("db_glitch", seen, 0);
    lat = 0;
    gpio_i[5] = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick(1);
      if (lat == 0 && status_o[5]) lat = i;
    end
    check("db_lat_min", lat >= 34, 1);
    check("db_lat_max", lat <= 43, 1);
    check("db_irq", irq_o, 1);

    gpio_i[5] = 1'b0;
    tick(15);
    check("pre_rst", status_o, 32'h20);
    rst_i = 1'b1;
    #1;
    check("mid_rst_status", status_o, 0);
    check("mid_rst_irq", irq_o, 0);
    check("mid_rst_id", irq_id_o, 0);
    check("mid_rst_valid", irq_valid_o, 0);
    tick(3);
    rst_i = 1'b0;
    tick(10);
    check("post_rst", status_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
